ram: RTL and testbench

//  16 x 8 synchronous-write, asynchronous-read RAM for the 8-bit CPU.
//  - Sits on the shared 8-bit CPU bus through bidirectional port RAM_BUS.
//  - Writes are captured from the bus in programming mode (pc_in=1).
//  - Reads drive the bus only when output enable OE_n is low.

---
 rtl/ram.sv | 70 +++++++
 tb/tb_ram.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram.sv
// rtl/ram.sv - 16 x 8 synchronous-write, asynchronous-read RAM on a shared bidirectional CPU bus
//
// Purpose:
//   Word store for the 8-bit CPU. Writes are captured from RAM_BUS on the
//   rising clock edge in program mode. Reads drive RAM_BUS combinationally
//   in run mode when the output enable is asserted. The bus is released (Z)
//   in every other case, so the block never fights another bus driver.
//
// Optional feature:
//   RAM_CLEAR_ON_RESET_EN - when defined, every clock edge with rst_n low
//   clears all words to zero. When undefined, reset only blocks writes and
//   the bus driver, and the memory keeps its contents.
//
// Ports:
//   clk      in     1       system clock, rising edge
//   rst_n    in     1       synchronous active-low reset
//   address  in     ADDR_W  word address for read and write
//   pc_in    in     1       1 = program/write mode, 0 = run/read mode
//   OE_n     in     1       active-low output enable for reads
//   EN       in     1       write enable, qualified by pc_in
//   RAM_BUS  inout  DATA_W  shared bus: write data in, read data out

module ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              pc_in,
  input  logic              OE_n,
  input  logic              EN,
  inout  wire  [DATA_W-1:0] RAM_BUS
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic wr_en;
  logic rd_en;

  // A write request overrides the output enable: EN=1 blocks the read
  // driver, so the bus is free to carry write data into the array.
  assign wr_en = rst_n & pc_in & EN;
  assign rd_en = rst_n & ~OE_n & ~pc_in & ~EN;

`ifdef RAM_CLEAR_ON_RESET_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[address] <= RAM_BUS;
    end
  end
`else
  // Contents survive reset; reset only suppresses the write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[address] <= RAM_BUS;
    end
  end
`endif

  // Read path has no register: the bus follows address changes immediately.
  assign RAM_BUS = rd_en ? mem[address] : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ram.sv
// tb/tb_ram.sv - self-checking bench for ram with a read-value scoreboard

module tb_ram;

  logic       clk;
  logic       rst_n;
  logic [3:0] address;
  logic       pc_in;
  logic       OE_n;
  logic       EN;
  logic [7:0] tb_drv;
  logic       tb_en;
  wire  [7:0] RAM_BUS;

  assign RAM_BUS = tb_en ? tb_drv : 8'bz;

  ram dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .address (address),
    .pc_in   (pc_in),
    .OE_n    (OE_n),
    .EN      (EN),
    .RAM_BUS (RAM_BUS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks;
  int         failures;
  logic [7:0] model [16];
  logic [7:0] exp_q [$];
  logic [7:0] got;
  logic [7:0] exp_v;

  // Drive a program-mode write; the model takes the value once the edge passes.
  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    pc_in   = 1'b1;
    EN      = 1'b1;
    OE_n    = 1'b1;
    address = a;
    tb_en   = 1'b1;
    tb_drv  = d;
    @(posedge clk);
    if (rst_n) model[a] = d;
    #1;
  endtask

  // Set up a run-mode read and push the value the RAM should put on the bus.
  task automatic start_read(input logic [3:0] a);
    @(negedge clk);
    pc_in   = 1'b0;
    EN      = 1'b0;
    OE_n    = 1'b0;
    tb_en   = 1'b0;
    address = a;
    exp_q.push_back(model[a]);
    #2;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    pc_in = 1'b0; EN = 1'b0; OE_n = 1'b0; address = 4'h0;
    tb_en = 1'b1; tb_drv = 8'h00;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (RAM_BUS !== 8'h00) begin
      failures++;
      $display("FAIL reset_probe_00 got=%h exp=%h", RAM_BUS, 8'h00);
    end
    tb_drv = 8'hFF;
    #1;
    checks++;
    if (RAM_BUS !== 8'hFF) begin
      failures++;
      $display("FAIL reset_probe_ff got=%h exp=%h", RAM_BUS, 8'hFF);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tb_en = 1'b0;
    OE_n  = 1'b1;
  endtask

  task automatic test_write_read;
    do_write(4'h0, 8'hAA);
    start_read(4'h0);
    @(posedge clk);
    #1;
    got = RAM_BUS;
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v || exp_v !== 8'hAA) begin
      failures++;
      $display("FAIL write_read_0 got=%h exp=%h", got, 8'hAA);
    end
  endtask

  task automatic test_boundary;
    do_write(4'hF, 8'h55);
    start_read(4'hF);
    got = RAM_BUS;
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL boundary_f got=%h exp=%h", got, exp_v);
    end
    start_read(4'h0);
    got = RAM_BUS;
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL boundary_0_kept got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_patterns;
    do_write(4'h2, 8'h00);
    do_write(4'h3, 8'hFF);
    start_read(4'h2);
    start_read(4'h3);
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        address = 4'h2;
      end else begin
        address = 4'h3;
      end
      #1;
      got = RAM_BUS;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pattern_queue_empty got=%h exp=none", got);
      end else begin
        exp_v = exp_q.pop_front();
        if (got !== exp_v) begin
          failures++;
          $display("FAIL pattern_%0d got=%h exp=%h", i, got, exp_v);
        end
      end
    end
  endtask

  task automatic test_output_enable;
    do_write(4'h4, 8'hCC);
    @(negedge clk);
    pc_in = 1'b0; EN = 1'b0; OE_n = 1'b1; address = 4'h4;
    tb_en = 1'b1; tb_drv = 8'h00;
    #1;
    checks++;
    if (RAM_BUS !== 8'h00) begin
      failures++;
      $display("FAIL oe_off_probe_00 got=%h exp=%h", RAM_BUS, 8'h00);
    end
    tb_drv = 8'hFF;
    #1;
    checks++;
    if (RAM_BUS !== 8'hFF) begin
      failures++;
      $display("FAIL oe_off_probe_ff got=%h exp=%h", RAM_BUS, 8'hFF);
    end
    start_read(4'h4);
    got = RAM_BUS;
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v || got !== 8'hCC) begin
      failures++;
      $display("FAIL oe_on_4 got=%h exp=%h", got, 8'hCC);
    end
  endtask

  task automatic test_gating;
    // EN without program mode must not write.
    @(negedge clk);
    pc_in = 1'b0; EN = 1'b1; OE_n = 1'b1; address = 4'h4;
    tb_en = 1'b1; tb_drv = 8'h11;
    @(posedge clk);
    #1;
    start_read(4'h4);
    got = RAM_BUS;
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL en_without_pc got=%h exp=%h", got, exp_v);
    end
    // Write request with OE_n low: the block must leave the bus alone.
    @(negedge clk);
    pc_in = 1'b1; EN = 1'b1; OE_n = 1'b0; address = 4'h5;
    tb_en = 1'b1; tb_drv = 8'h00;
    #1;
    checks++;
    if (RAM_BUS !== 8'h00) begin
      failures++;
      $display("FAIL write_oe_probe_00 got=%h exp=%h", RAM_BUS, 8'h00);
    end
    tb_drv = 8'hFF;
    #1;
    checks++;
    if (RAM_BUS !== 8'hFF) begin
      failures++;
      $display("FAIL write_oe_probe_ff got=%h exp=%h", RAM_BUS, 8'hFF);
    end
    @(posedge clk);
    model[5] = 8'hFF;
    #1;
    start_read(4'h5);
    got = RAM_BUS;
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL write_wins_5 got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_back_to_back;
    do_write(4'h7, 8'h3C);
    do_write(4'h8, 8'hC3);
    start_read(4'h7);
    got = RAM_BUS;
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL b2b_7 got=%h exp=%h", got, exp_v);
    end
    // Same cycle address change: bus must follow with no edge in between.
    address = 4'h8;
    exp_q.push_back(model[8]);
    #1;
    got = RAM_BUS;
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL addr_follow_8 got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_reset_mid_write;
    @(negedge clk);
    rst_n = 1'b0;
    pc_in = 1'b0; EN = 1'b0; OE_n = 1'b0; address = 4'h0;
    tb_en = 1'b1; tb_drv = 8'h00;
    #1;
    checks++;
    if (RAM_BUS !== 8'h00) begin
      failures++;
      $display("FAIL rst_oe_probe_00 got=%h exp=%h", RAM_BUS, 8'h00);
    end
    tb_drv = 8'hFF;
    #1;
    checks++;
    if (RAM_BUS !== 8'hFF) begin
      failures++;
      $display("FAIL rst_oe_probe_ff got=%h exp=%h", RAM_BUS, 8'hFF);
    end
    // Write attempt at the reset edge must be dropped.
    pc_in = 1'b1; EN = 1'b1; OE_n = 1'b1; tb_drv = 8'h77;
    @(posedge clk);
`ifdef RAM_CLEAR_ON_RESET_EN
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
`endif
    #1;
    rst_n = 1'b1;
    start_read(4'h0);
    got = RAM_BUS;
    exp_v = exp_q.pop_front();
    checks++;
`ifdef RAM_CLEAR_ON_RESET_EN
    if (got !== exp_v || got !== 8'h00) begin
      failures++;
      $display("FAIL reset_addr0 got=%h exp=%h", got, 8'h00);
    end
`else
    if (got !== exp_v || got !== 8'hAA) begin
      failures++;
      $display("FAIL reset_addr0 got=%h exp=%h", got, 8'hAA);
    end
`endif
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    pc_in    = 1'b0;
    EN       = 1'b0;
    OE_n     = 1'b1;
    address  = 4'h0;
    tb_en    = 1'b0;
    tb_drv   = 8'h00;
    for (int i = 0; i < 16; i++) model[i] = 8'hxx;
    test_reset;
    test_write_read;
    test_boundary;
    test_patterns;
    test_output_enable;
    test_gating;
    test_back_to_back;
    test_reset_mid_write;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
